// File: rtl/ttl_74191_pkg.sv
// ttl_74191_pkg: shared operation type and decode for the 74191 up/down counter
//   op_t       - what the counter register does at the next rising clock edge
//   decode_op  - priority decode: load beats enable, enable gates counting
package ttl_74191_pkg;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_UP, OP_DOWN} op_t;
  function automatic op_t decode_op(input logic load_bar, input logic enable_bar, input logic down_up);
    return !load_bar ? OP_LOAD : enable_bar ? OP_HOLD : down_up ? OP_DOWN : OP_UP;
  endfunction
endpackage

// File: rtl/ttl_74191.sv
// ttl_74191: presettable synchronous up/down binary counter with max/min and ripple-clock outputs
//   Clk            rising-edge clock
//   Clear_bar      asynchronous active-low clear, Q = 0
//   Load_bar       synchronous active-low parallel load of D (beats Enable_bar)
//   Enable_bar     active-low count enable
//   Down_Up        0 = up, 1 = down
//   D / Q          parallel load data / counter state
//   Max_Min        terminal count for the current direction (combinational)
//   Ripple_Clk_bar low during Clk-low phase while enabled at terminal count
module ttl_74191 import ttl_74191_pkg::*; #(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             Enable_bar,
  input  logic             Down_Up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Max_Min,
  output logic             Ripple_Clk_bar
);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             mm;
  op_t              op;
  always_comb begin
    op    = decode_op(Load_bar, Enable_bar, Down_Up);
    q_nxt = op == OP_LOAD ? D :
            op == OP_UP   ? q + WIDTH'(1) :
            op == OP_DOWN ? q - WIDTH'(1) : q;
  end
  always_ff @(posedge Clk or negedge Clear_bar)
    if (!Clear_bar) q <= '0;
    else            q <= q_nxt;
  // Direction is not registered, so flipping Down_Up moves Max_Min without a clock.
  assign mm = Down_Up ? (q == '0) : (q == ALL_ONES);
  // The implementation is zero-delay; the delay parameters only gate legal configurations.
  if (WIDTH >= 2 && DELAY_RISE >= 0 && DELAY_FALL >= 0) begin : g_out
    assign Q              = q;
    assign Max_Min        = mm;
    assign Ripple_Clk_bar = ~(~Enable_bar & mm & ~Clk);
  end else begin : g_bad
    assign Q              = '0;
    assign Max_Min        = 1'b0;
    assign Ripple_Clk_bar = 1'b1;
  end
endmodule

// File: tb/tb_ttl_74191.sv
// tb_ttl_74191: self-checking bench for ttl_74191 with a two-stage cascade and a modular reference model
module tb_ttl_74191;
  logic       clk;
  logic       clear_bar, load_bar, enable_bar, down_up;
  logic [3:0] d, q;
  logic       max_min, ripple;
  logic       c_clr, c_en, c_dn, c_ld;
  logic [3:0] c_d, lo_q, hi_q;
  logic       lo_mm, lo_rc, hi_mm, hi_rc;
  int n_cmp = 0;
  int n_bad = 0;
  int m;
  ttl_74191 #(.WIDTH(4)) dut (.Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar), .Enable_bar(enable_bar),
    .Down_Up(down_up), .D(d), .Q(q), .Max_Min(max_min), .Ripple_Clk_bar(ripple));
  ttl_74191 #(.WIDTH(4)) lo (.Clk(clk), .Clear_bar(c_clr), .Load_bar(c_ld), .Enable_bar(c_en),
    .Down_Up(c_dn), .D(c_d), .Q(lo_q), .Max_Min(lo_mm), .Ripple_Clk_bar(lo_rc));
  ttl_74191 #(.WIDTH(4)) hi (.Clk(lo_rc), .Clear_bar(c_clr), .Load_bar(c_ld), .Enable_bar(c_en),
    .Down_Up(c_dn), .D(c_d), .Q(hi_q), .Max_Min(hi_mm), .Ripple_Clk_bar(hi_rc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic exp_mm(input int v, input logic dn);
    return dn ? (v == 0) : (v == 15);
  endfunction
  task automatic load_val(input logic [3:0] v);
    load_bar = 1'b0;
    d = v;
    @(posedge clk); #1;
    load_bar = 1'b1;
  endtask
  task automatic test_reset;
    #2;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_q got %h want 0", q); end
    n_cmp++; if (max_min !== 1'b0) begin n_bad++; $display("FAIL reset_mm_up got %b want 0", max_min); end
    down_up = 1'b1; #1;
    n_cmp++; if (max_min !== 1'b1) begin n_bad++; $display("FAIL reset_mm_down got %b want 1", max_min); end
    down_up = 1'b0;
    #9 clear_bar = 1'b1; c_clr = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL reset_hold got %h want 0", q); end
    n_cmp++; if (ripple !== 1'b1) begin n_bad++; $display("FAIL reset_ripple got %b want 1", ripple); end
  endtask
  task automatic test_clear_mid;
    enable_bar = 1'b1;
    load_val(4'h9);
    n_cmp++; if (q !== 4'h9) begin n_bad++; $display("FAIL clr_pre got %h want 9", q); end
    enable_bar = 1'b0;
    #2 down_up = 1'b1; clear_bar = 1'b0;
    #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL clr_mid_q got %h want 0", q); end
    n_cmp++; if (max_min !== 1'b1) begin n_bad++; $display("FAIL clr_mid_mm got %b want 1", max_min); end
    @(negedge clk); clear_bar = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL clr_after got %h want f", q); end
    enable_bar = 1'b1;
    down_up = 1'b0;
  endtask
  task automatic test_up_wrap;
    load_val(4'hE);
    enable_bar = 1'b0;
    down_up = 1'b0;
    n_cmp++; if (max_min !== 1'b0) begin n_bad++; $display("FAIL up_mm_e got %b want 0", max_min); end
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL up_q_f got %h want f", q); end
    n_cmp++; if (max_min !== 1'b1) begin n_bad++; $display("FAIL up_mm_f got %b want 1", max_min); end
    n_cmp++; if (ripple !== 1'b1) begin n_bad++; $display("FAIL up_rc_high got %b want 1", ripple); end
    @(negedge clk); #1;
    n_cmp++; if (ripple !== 1'b0) begin n_bad++; $display("FAIL up_rc_low got %b want 0", ripple); end
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL up_wrap got %h want 0", q); end
    n_cmp++; if (max_min !== 1'b0) begin n_bad++; $display("FAIL up_mm_0 got %b want 0", max_min); end
    @(negedge clk); #1;
    n_cmp++; if (ripple !== 1'b1) begin n_bad++; $display("FAIL up_rc_0 got %b want 1", ripple); end
    @(posedge clk); #1;
    enable_bar = 1'b1;
  endtask
  task automatic test_down_wrap;
    load_val(4'h1);
    enable_bar = 1'b0;
    down_up = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'h0) begin n_bad++; $display("FAIL dn_q_0 got %h want 0", q); end
    n_cmp++; if (max_min !== 1'b1) begin n_bad++; $display("FAIL dn_mm_0 got %b want 1", max_min); end
    down_up = 1'b0; #1;
    n_cmp++; if (max_min !== 1'b0) begin n_bad++; $display("FAIL dn_toggle_mm got %b want 0", max_min); end
    down_up = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL dn_wrap got %h want f", q); end
    n_cmp++; if (max_min !== 1'b0) begin n_bad++; $display("FAIL dn_mm_f got %b want 0", max_min); end
    enable_bar = 1'b1;
    down_up = 1'b0;
  endtask
  task automatic test_load;
    enable_bar = 1'b1;
    load_val(4'h5);
    n_cmp++; if (q !== 4'h5) begin n_bad++; $display("FAIL load_dis got %h want 5", q); end
    enable_bar = 1'b0;
    load_val(4'hA);
    n_cmp++; if (q !== 4'hA) begin n_bad++; $display("FAIL load_en_up got %h want a", q); end
    down_up = 1'b1;
    load_val(4'h3);
    n_cmp++; if (q !== 4'h3) begin n_bad++; $display("FAIL load_en_dn got %h want 3", q); end
    enable_bar = 1'b1;
    down_up = 1'b0;
  endtask
  task automatic test_hold;
    load_val(4'hF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (q !== 4'hF) begin n_bad++; $display("FAIL hold_q[%0d] got %h want f", i, q); end
      n_cmp++; if (max_min !== 1'b1) begin n_bad++; $display("FAIL hold_mm[%0d] got %b want 1", i, max_min); end
      @(negedge clk); #1;
      n_cmp++; if (ripple !== 1'b1) begin n_bad++; $display("FAIL hold_rc[%0d] got %b want 1", i, ripple); end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_cascade;
    int cm;
    c_clr = 1'b0; #1 c_clr = 1'b1;
    c_dn = 1'b0;
    c_en = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    n_cmp++; if ({hi_q, lo_q} !== 8'h0F) begin n_bad++; $display("FAIL casc_0f got %h want 0f", {hi_q, lo_q}); end
    @(posedge clk); #1;
    n_cmp++; if ({hi_q, lo_q} !== 8'h10) begin n_bad++; $display("FAIL casc_up got %h want 10", {hi_q, lo_q}); end
    c_dn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({hi_q, lo_q} !== 8'h0F) begin n_bad++; $display("FAIL casc_dn got %h want 0f", {hi_q, lo_q}); end
    cm = 15;
    for (int i = 0; i < 60; i++) begin
      c_dn = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cm = c_dn ? (cm + 255) % 256 : (cm + 1) % 256;
      n_cmp++; if ({hi_q, lo_q} !== 8'(cm)) begin n_bad++; $display("FAIL casc_rand[%0d] got %h want %h", i, {hi_q, lo_q}, 8'(cm)); end
    end
    c_en = 1'b1;
  endtask
  task automatic test_random;
    m = int'(q);
    for (int i = 0; i < 200; i++) begin
      n_cmp++; if (q !== 4'(m)) begin n_bad++; $display("FAIL rand_q[%0d] got %h want %h", i, q, 4'(m)); end
      load_bar   = ($urandom_range(0, 7) != 0);
      enable_bar = ($urandom_range(0, 3) == 0);
      down_up    = 1'($urandom_range(0, 1));
      d          = 4'($urandom_range(0, 15));
      #1;
      n_cmp++; if (max_min !== exp_mm(m, down_up)) begin n_bad++; $display("FAIL rand_mm[%0d] got %b want %b", i, max_min, exp_mm(m, down_up)); end
      @(negedge clk); #1;
      n_cmp++; if (ripple !== !(!enable_bar && exp_mm(m, down_up))) begin n_bad++; $display("FAIL rand_rc[%0d] got %b want %b", i, ripple, !(!enable_bar && exp_mm(m, down_up))); end
      @(posedge clk); #1;
      if (!load_bar) m = int'(d);
      else if (!enable_bar) m = down_up ? (m + 15) % 16 : (m + 1) % 16;
    end
    n_cmp++; if (q !== 4'(m)) begin n_bad++; $display("FAIL rand_final got %h want %h", q, 4'(m)); end
    load_bar = 1'b1;
    enable_bar = 1'b1;
  endtask
  initial begin
    clear_bar = 1'b0; load_bar = 1'b1; enable_bar = 1'b1; down_up = 1'b0; d = 4'h0;
    c_clr = 1'b0; c_en = 1'b1; c_dn = 1'b0; c_ld = 1'b1; c_d = 4'h0;
    test_reset;
    test_clear_mid;
    test_up_wrap;
    test_down_wrap;
    test_load;
    test_hold;
    test_cascade;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
